// File: rtl/riscv_data_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : riscv_data_bus_responder
// Description : CPU data-bus target with byte-lane RAM, console output FIFO
//               with drop counter, and a free-running writable cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_data_bus_responder #(
  parameter int RAM_WORDS = 1024,
  parameter int CON_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_mem_wr_en,
  input  logic [31:0] i_mem_addr,
  input  logic [3:0]  i_mem_byte_sel,
  input  logic [31:0] i_mem_writedata,
  output logic [31:0] o_mem_readdata,
  output logic        o_con_valid,
  output logic [7:0]  o_con_data,
  input  logic        i_con_ready
);

  localparam int c_RAM_AW = $clog2(RAM_WORDS);
  localparam int c_CON_AW = (CON_DEPTH > 1) ? $clog2(CON_DEPTH) : 1;
  localparam logic [29:0] c_WA_CON_DATA   = 30'h0400_0000;
  localparam logic [29:0] c_WA_CON_STATUS = 30'h0400_0001;
  localparam logic [29:0] c_WA_CYCLE      = 30'h0400_0002;
  localparam logic [c_CON_AW:0]   c_COUNT_FULL = (c_CON_AW + 1)'(CON_DEPTH);
  localparam logic [c_CON_AW:0]   c_COUNT_ONE  = (c_CON_AW + 1)'(1);
  localparam logic [c_CON_AW-1:0] c_PTR_ONE    = (c_CON_AW)'(1);

  logic [31:0]         r_ram [RAM_WORDS];
  logic [7:0]          r_fifo [CON_DEPTH];
  logic [c_CON_AW-1:0] r_head;
  logic [c_CON_AW-1:0] r_tail;
  logic [c_CON_AW:0]   r_count;
  logic [7:0]          r_drop;
  logic [31:0]         r_cycle;

  logic [29:0]         w_wordAddr;
  logic [c_RAM_AW-1:0] w_ramIdx;
  logic                w_ramHit;
  logic                w_conDataHit;
  logic                w_conStatHit;
  logic                w_cycleHit;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_pushReq;
  logic                w_pushOk;
  logic [31:0]         w_laneMask;
  logic [31:0]         w_status;
  logic                w_unusedAddrBits;

  assign w_wordAddr       = i_mem_addr[31:2];
  assign w_ramIdx         = i_mem_addr[c_RAM_AW+1:2];
  // RAM occupies the bottom of the map; anything at or above its size is a hole.
  assign w_ramHit         = (i_mem_addr[31:c_RAM_AW+2] == '0);
  assign w_conDataHit     = (w_wordAddr == c_WA_CON_DATA);
  assign w_conStatHit     = (w_wordAddr == c_WA_CON_STATUS);
  assign w_cycleHit       = (w_wordAddr == c_WA_CYCLE);
  assign w_unusedAddrBits = ^i_mem_addr[1:0];

  assign w_full    = (r_count == c_COUNT_FULL);
  assign w_empty   = (r_count == '0);
  assign w_pop     = !w_empty && i_con_ready;
  assign w_pushReq = i_mem_wr_en && w_conDataHit && i_mem_byte_sel[0];
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_pushOk  = w_pushReq && (!w_full || w_pop);

  assign w_laneMask = {{8{i_mem_byte_sel[3]}}, {8{i_mem_byte_sel[2]}},
                       {8{i_mem_byte_sel[1]}}, {8{i_mem_byte_sel[0]}}};
  assign w_status   = {16'h0000, r_drop, 6'(r_count), w_empty, w_full};

  assign o_con_valid = !w_empty;
  assign o_con_data  = r_fifo[r_head];

  always_comb begin
    o_mem_readdata = '0;
    if (w_ramHit)
      o_mem_readdata = r_ram[w_ramIdx];
    else if (w_conStatHit)
      o_mem_readdata = w_status;
    else if (w_cycleHit)
      o_mem_readdata = r_cycle;
  end

  // Storage arrays carry no reset; contents survive i_rstn.
  always_ff @(posedge i_clk) begin
    if (i_mem_wr_en && w_ramHit) begin
      for (int b = 0; b < 4; b++) begin
        if (i_mem_byte_sel[b])
          r_ram[w_ramIdx][8*b +: 8] <= i_mem_writedata[8*b +: 8];
      end
    end
    if (w_pushOk)
      r_fifo[r_tail] <= i_mem_writedata[7:0];
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_drop  <= '0;
      r_cycle <= '0;
    end else begin
      if (w_pushOk)
        r_tail <= r_tail + c_PTR_ONE;
      if (w_pop)
        r_head <= r_head + c_PTR_ONE;
      case ({w_pushOk, w_pop})
        2'b10:   r_count <= r_count + c_COUNT_ONE;
        2'b01:   r_count <= r_count - c_COUNT_ONE;
        default: r_count <= r_count;
      endcase

      if (i_mem_wr_en && w_conStatHit)
        r_drop <= '0;
      else if (w_pushReq && !w_pushOk && (r_drop != 8'hFF))
        r_drop <= r_drop + 8'd1;

      if (i_mem_wr_en && w_cycleHit)
        r_cycle <= (r_cycle & ~w_laneMask) | (i_mem_writedata & w_laneMask);
      else
        r_cycle <= r_cycle + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_data_bus_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_data_bus_responder
// Description : Directed self-checking bench for riscv_data_bus_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_riscv_data_bus_responder;

  localparam logic [31:0] c_CON_DATA   = 32'h1000_0000;
  localparam logic [31:0] c_CON_STATUS = 32'h1000_0004;
  localparam logic [31:0] c_CYCLE      = 32'h1000_0008;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wrEn = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        conValid;
  logic [7:0]  conData;
  logic        conReady = 1'b0;

  int total = 0;
  int bad = 0;

  riscv_data_bus_responder #(.RAM_WORDS(1024), .CON_DEPTH(4)) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_mem_wr_en    (wrEn),
    .i_mem_addr     (addr),
    .i_mem_byte_sel (sel),
    .i_mem_writedata(wdata),
    .o_mem_readdata (rdata),
    .o_con_valid    (conValid),
    .o_con_data     (conData),
    .i_con_ready    (conReady)
  );

  always #10 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic readWord(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    addr  = a;
    wdata = d;
    sel   = s;
    wrEn  = 1'b1;
    @(posedge clk);
    #1;
    wrEn = 1'b0;
    sel  = 4'h0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    #3;
    total++;
    if (conValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h want=0", conValid); end
    readWord(c_CON_STATUS, d);
    total++;
    if (d !== 32'h0000_0002) begin bad++; $display("FAIL reset_status got=%08h want=00000002", d); end
    readWord(c_CYCLE, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_cycle got=%08h want=00000000", d); end
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    readWord(c_CYCLE, d);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL cycle_first got=%08h want=00000001", d); end
    @(posedge clk);
    #1;
    readWord(c_CYCLE, d);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL cycle_second got=%08h want=00000002", d); end
  endtask

  task automatic test_ram;
    logic [31:0] d;
    busWrite(32'h0000_0000, 32'h0BAD_F00D, 4'b1111);
    busWrite(32'h0000_0010, 32'hAABB_CCDD, 4'b1111);
    busWrite(32'h0000_0010, 32'h0000_1100, 4'b0010);
    readWord(32'h0000_0010, d);
    total++;
    if (d !== 32'hAABB_11DD) begin bad++; $display("FAIL ram_lane got=%08h want=AABB11DD", d); end
    busWrite(32'h0000_0010, 32'hFFFF_FFFF, 4'b0000);
    readWord(32'h0000_0012, d);
    total++;
    if (d !== 32'hAABB_11DD) begin bad++; $display("FAIL ram_sel0 got=%08h want=AABB11DD", d); end
    busWrite(32'h0000_0014, 32'h1234_5678, 4'b1111);
    addr  = 32'h0000_0014;
    wdata = 32'h9ABC_DEF0;
    sel   = 4'b1111;
    wrEn  = 1'b1;
    #1;
    total++;
    if (rdata !== 32'h1234_5678) begin bad++; $display("FAIL ram_old got=%08h want=12345678", rdata); end
    @(posedge clk);
    #1;
    wrEn = 1'b0;
    readWord(32'h0000_0014, d);
    total++;
    if (d !== 32'h9ABC_DEF0) begin bad++; $display("FAIL ram_new got=%08h want=9ABCDEF0", d); end
    busWrite(32'h0000_0FFC, 32'hCAFE_BABE, 4'b1111);
    readWord(32'h0000_0FFC, d);
    total++;
    if (d !== 32'hCAFE_BABE) begin bad++; $display("FAIL ram_top got=%08h want=CAFEBABE", d); end
    busWrite(32'h0000_1000, 32'hDEAD_BEEF, 4'b1111);
    readWord(32'h0000_1000, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL ram_beyond got=%08h want=00000000", d); end
    readWord(32'h0000_0000, d);
    total++;
    if (d !== 32'h0BAD_F00D) begin bad++; $display("FAIL ram_alias got=%08h want=0BADF00D", d); end
    readWord(32'h0FFF_FFF0, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL ram_hole got=%08h want=00000000", d); end
  endtask

  task automatic test_console;
    logic [31:0] d;
    conReady = 1'b0;
    busWrite(c_CON_DATA, 32'h0000_0077, 4'b1110);
    readWord(c_CON_STATUS, d);
    total++;
    if (d !== 32'h0000_0002) begin bad++; $display("FAIL con_nolane got=%08h want=00000002", d); end
    for (int i = 0; i < 4; i++)
      busWrite(c_CON_DATA, 32'h41 + i, 4'b0001);
    readWord(c_CON_STATUS, d);
    total++;
    if (d !== 32'h0000_0011) begin bad++; $display("FAIL con_full got=%08h want=00000011", d); end
    busWrite(c_CON_DATA, 32'h45, 4'b0001);
    readWord(c_CON_STATUS, d);
    total++;
    if (d !== 32'h0000_0111) begin bad++; $display("FAIL con_drop got=%08h want=00000111", d); end
    total++;
    if (conValid !== 1'b1 || conData !== 8'h41) begin
      bad++; $display("FAIL con_head got=%0h/%02h want=1/41", conValid, conData);
    end
    readWord(c_CON_DATA, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL con_dataread got=%08h want=00000000", d); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d;
    logic [7:0]  exp [4];
    exp[0] = 8'h42; exp[1] = 8'h43; exp[2] = 8'h44; exp[3] = 8'h46;
    addr  = c_CON_DATA;
    wdata = 32'h46;
    sel   = 4'b0001;
    wrEn  = 1'b1;
    conReady = 1'b1;
    #1;
    total++;
    if (conData !== 8'h41) begin bad++; $display("FAIL b2b_head got=%02h want=41", conData); end
    @(posedge clk);
    #1;
    wrEn = 1'b0;
    sel  = 4'h0;
    conReady = 1'b0;
    readWord(c_CON_STATUS, d);
    total++;
    if (d !== 32'h0000_0111) begin bad++; $display("FAIL b2b_status got=%08h want=00000111", d); end
    for (int i = 0; i < 4; i++) begin
      conReady = 1'b1;
      #1;
      total++;
      if (conValid !== 1'b1 || conData !== exp[i]) begin
        bad++; $display("FAIL b2b_drain%0d got=%0h/%02h want=1/%02h", i, conValid, conData, exp[i]);
      end
      @(posedge clk);
      #1;
    end
    conReady = 1'b0;
    readWord(c_CON_STATUS, d);
    total++;
    if (conValid !== 1'b0 || d !== 32'h0000_0102) begin
      bad++; $display("FAIL b2b_empty got=%0h/%08h want=0/00000102", conValid, d);
    end
    busWrite(c_CON_STATUS, 32'h0, 4'b1111);
    readWord(c_CON_STATUS, d);
    total++;
    if (d !== 32'h0000_0002) begin bad++; $display("FAIL drop_clear got=%08h want=00000002", d); end
  endtask

  task automatic test_drop_saturate;
    logic [31:0] d;
    conReady = 1'b0;
    for (int i = 0; i < 4; i++)
      busWrite(c_CON_DATA, 32'h50 + i, 4'b0001);
    for (int i = 0; i < 256; i++)
      busWrite(c_CON_DATA, 32'hEE, 4'b0001);
    readWord(c_CON_STATUS, d);
    total++;
    if (d !== 32'h0000_FF11) begin bad++; $display("FAIL drop_sat got=%08h want=0000FF11", d); end
    busWrite(c_CON_STATUS, 32'h0, 4'b0000);
    readWord(c_CON_STATUS, d);
    total++;
    if (d !== 32'h0000_0011) begin bad++; $display("FAIL drop_sat_clear got=%08h want=00000011", d); end
    for (int i = 0; i < 4; i++) begin
      conReady = 1'b1;
      #1;
      total++;
      if (conData !== 8'(8'h50 + i)) begin
        bad++; $display("FAIL wrap_drain%0d got=%02h want=%02h", i, conData, 8'(8'h50 + i));
      end
      @(posedge clk);
      #1;
    end
    conReady = 1'b0;
    readWord(c_CON_STATUS, d);
    total++;
    if (d !== 32'h0000_0002) begin bad++; $display("FAIL wrap_empty got=%08h want=00000002", d); end
  endtask

  task automatic test_cycle;
    logic [31:0] d;
    busWrite(c_CYCLE, 32'hFFFF_FFFE, 4'b1111);
    readWord(c_CYCLE, d);
    total++;
    if (d !== 32'hFFFF_FFFE) begin bad++; $display("FAIL cycle_load got=%08h want=FFFFFFFE", d); end
    @(posedge clk);
    #1;
    readWord(c_CYCLE, d);
    total++;
    if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cycle_max got=%08h want=FFFFFFFF", d); end
    @(posedge clk);
    #1;
    readWord(c_CYCLE, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL cycle_wrap got=%08h want=00000000", d); end
    busWrite(c_CYCLE, 32'h1200_0000, 4'b1000);
    readWord(c_CYCLE, d);
    total++;
    if (d !== 32'h1200_0000) begin bad++; $display("FAIL cycle_lane got=%08h want=12000000", d); end
    @(posedge clk);
    #1;
    readWord(c_CYCLE, d);
    total++;
    if (d !== 32'h1200_0001) begin bad++; $display("FAIL cycle_resume got=%08h want=12000001", d); end
  endtask

  task automatic test_unmapped_reset;
    logic [31:0] d;
    conReady = 1'b0;
    for (int i = 0; i < 3; i++)
      busWrite(c_CON_DATA, 32'h61 + i, 4'b0001);
    readWord(32'h2000_0000, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%08h want=00000000", d); end
    busWrite(32'h1000_000C, 32'hFFFF_FFFF, 4'b1111);
    readWord(c_CON_STATUS, d);
    total++;
    if (d !== 32'h0000_000C) begin bad++; $display("FAIL unmapped_status got=%08h want=0000000C", d); end
    readWord(32'h0000_0000, d);
    total++;
    if (d !== 32'h0BAD_F00D) begin bad++; $display("FAIL unmapped_ram got=%08h want=0BADF00D", d); end
    rstn = 1'b0;
    #1;
    total++;
    if (conValid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0h want=0", conValid); end
    readWord(c_CON_STATUS, d);
    total++;
    if (d !== 32'h0000_0002) begin bad++; $display("FAIL rst_status got=%08h want=00000002", d); end
    readWord(c_CYCLE, d);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rst_cycle got=%08h want=00000000", d); end
    readWord(32'h0000_0010, d);
    total++;
    if (d !== 32'hAABB_11DD) begin bad++; $display("FAIL rst_ram got=%08h want=AABB11DD", d); end
    busWrite(c_CON_DATA, 32'h99, 4'b0001);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    readWord(c_CYCLE, d);
    total++;
    if (d !== 32'h1 || conValid !== 1'b0) begin
      bad++; $display("FAIL rst_release got=%08h/%0h want=00000001/0", d, conValid);
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_console();
    test_back_to_back();
    test_drop_saturate();
    test_cycle();
    test_unmapped_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
